// File: rtl/jtag_dmi_host.sv
// jtag_dmi_host: JTAG initiator that turns one DMI request (op, addr, data) into a
// full TAP sequence (IR select of DMI when needed, DR scan, Run-Test/Idle) and
// returns the status/data captured during that DR scan.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_op/req_addr/req_data latched on accept
//   rsp_valid            one-cycle pulse; rsp_op/rsp_data hold until the next response
//   busy                 a TAP sequence is in progress
//   tck/tms/tdi/tdo      JTAG pins toward the debug transport
//
// Optional feature macro: JTAG_DMI_HOST_AUTOFETCH_EN
//   When defined, each request is followed by nop scans that fetch the result of the
//   requested access itself (one extra nop if the first fetch reports busy).
module jtag_dmi_host #(
  parameter int unsigned       ABITS      = 7,
  parameter int unsigned       TCK_DIV    = 2,
  parameter int unsigned       IR_LEN     = 5,
  parameter logic [IR_LEN-1:0] IR_DMI     = IR_LEN'(5'h11),
  parameter int unsigned       RTI_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ABITS-1:0] req_addr,
  input  logic [31:0]      req_data,
  output logic             rsp_valid,
  output logic [1:0]       rsp_op,
  output logic [31:0]      rsp_data,
  output logic             busy,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo
);

  localparam int unsigned DRW = ABITS + 34;

  typedef enum logic [3:0] {
    StTlr, StIdle, StIrHdr, StIrShift, StIrTail,
    StDrHdr, StDrShift, StDrTail, StRti, StResp
  } state_e;

  state_e            st_q;
  logic [15:0]       cnt_q;
  logic [15:0]       div_q;
  logic              tck_q, tms_q, tdi_q;
  logic              ready_q, busy_q, rsp_valid_q, ir_loaded_q;
  logic [1:0]        rsp_op_q;
  logic [31:0]       rsp_data_q;
  logic [DRW-1:0]    sh_q, cap_q;
  logic [IR_LEN-1:0] ir_sh_q;
`ifdef JTAG_DMI_HOST_AUTOFETCH_EN
  logic [ABITS-1:0]  addr_q;
  logic [1:0]        fetch_q;
`endif

  logic              tck_run, div_hit, tck_rise, tck_fall, accept;
  logic [DRW-1:0]    sh_nx;
  logic [IR_LEN-1:0] ir_nx;

  always_comb begin
    tck_run  = (st_q != StIdle) && (st_q != StResp);
    div_hit  = (div_q == 16'(TCK_DIV - 1));
    tck_rise = tck_run && div_hit && !tck_q;
    tck_fall = tck_run && div_hit && tck_q;
    accept   = req_valid && ready_q;
    sh_nx    = sh_q >> 1;
    ir_nx    = ir_sh_q >> 1;
  end

  // Each FSM step happens on a tck falling edge and sets tms/tdi for the next bit,
  // so the TAP sees them stable across the following rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StTlr;
      cnt_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      ir_loaded_q <= 1'b0;
      sh_q        <= '0;
      cap_q       <= '0;
      ir_sh_q     <= '0;
`ifdef JTAG_DMI_HOST_AUTOFETCH_EN
      addr_q      <= '0;
      fetch_q     <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      if (tck_run) begin
        if (div_hit) begin
          div_q <= '0;
          tck_q <= ~tck_q;
        end else begin
          div_q <= div_q + 16'd1;
        end
      end
      // Target's DR bits arrive LSB first; shift in at the MSB end.
      if (tck_rise && st_q == StDrShift) cap_q <= {tdo, cap_q[DRW-1:1]};

      case (st_q)
        StIdle: begin
          if (accept) begin
            sh_q    <= {req_addr, req_data, req_op};
            ir_sh_q <= IR_DMI;
            cnt_q   <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            st_q    <= ir_loaded_q ? StDrHdr : StIrHdr;
`ifdef JTAG_DMI_HOST_AUTOFETCH_EN
            addr_q  <= req_addr;
            fetch_q <= '0;
`endif
          end
        end
        StResp: begin
          rsp_valid_q <= 1'b1;
          rsp_op_q    <= cap_q[1:0];
          rsp_data_q  <= cap_q[33:2];
          busy_q      <= 1'b0;
          ready_q     <= 1'b1;
          tms_q       <= 1'b0;
          st_q        <= StIdle;
        end
        default: begin
          if (tck_fall) begin
            cnt_q <= cnt_q + 16'd1;
            case (st_q)
              StTlr: begin
                if (cnt_q == 16'd5) begin
                  st_q    <= StIdle;
                  tms_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                end else begin
                  tms_q <= (cnt_q < 16'd4);
                end
              end
              StIrHdr: begin
                if (cnt_q == 16'd3) begin
                  st_q  <= StIrShift;
                  cnt_q <= '0;
                  tms_q <= (IR_LEN == 1);
                  tdi_q <= ir_sh_q[0];
                end else begin
                  tms_q <= (cnt_q == 16'd0);
                end
              end
              StIrShift: begin
                if (cnt_q == 16'(IR_LEN - 1)) begin
                  st_q  <= StIrTail;
                  cnt_q <= '0;
                  tms_q <= 1'b1;
                  tdi_q <= 1'b0;
                end else begin
                  ir_sh_q <= ir_nx;
                  tdi_q   <= ir_nx[0];
                  tms_q   <= (cnt_q == 16'(IR_LEN - 2));
                end
              end
              StIrTail: begin
                if (cnt_q == 16'd1) begin
                  ir_loaded_q <= 1'b1;
                  st_q        <= StDrHdr;
                  cnt_q       <= '0;
                  tms_q       <= 1'b1;
                end else begin
                  tms_q <= 1'b0;
                end
              end
              StDrHdr: begin
                tms_q <= 1'b0;
                if (cnt_q == 16'd2) begin
                  st_q  <= StDrShift;
                  cnt_q <= '0;
                  tdi_q <= sh_q[0];
                end
              end
              StDrShift: begin
                if (cnt_q == 16'(DRW - 1)) begin
                  st_q  <= StDrTail;
                  cnt_q <= '0;
                  tms_q <= 1'b1;
                  tdi_q <= 1'b0;
                end else begin
                  sh_q  <= sh_nx;
                  tdi_q <= sh_nx[0];
                  tms_q <= (cnt_q == 16'(DRW - 2));
                end
              end
              StDrTail: begin
                tms_q <= 1'b0;
                if (cnt_q == 16'd1) begin
                  st_q  <= StRti;
                  cnt_q <= '0;
                end
              end
              StRti: begin
                tms_q <= 1'b0;
                if (cnt_q == 16'(RTI_CYCLES - 1)) begin
                  cnt_q <= '0;
`ifdef JTAG_DMI_HOST_AUTOFETCH_EN
                  // First fetch always; a second only if the first came back busy.
                  if (fetch_q == 2'd0 || (fetch_q == 2'd1 && cap_q[1:0] == 2'b11)) begin
                    fetch_q <= fetch_q + 2'd1;
                    sh_q    <= {addr_q, 34'd0};
                    tms_q   <= 1'b1;
                    st_q    <= StDrHdr;
                  end else begin
                    st_q <= StResp;
                  end
`else
                  st_q <= StResp;
`endif
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_data  = rsp_data_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_dmi_host.sv
// Bench for jtag_dmi_host: a behavioural TAP/DMI target sits on the pins, a
// request-level model predicts TCK counts, scanned values and responses.
module tb_jtag_dmi_host;

  localparam int unsigned       ABITS      = 7;
  localparam int unsigned       TCK_DIV    = 2;
  localparam int unsigned       IR_LEN     = 5;
  localparam logic [IR_LEN-1:0] IR_DMI     = 5'h11;
  localparam int unsigned       RTI_CYCLES = 1;
  localparam int unsigned       DRW        = ABITS + 34;
`ifdef JTAG_DMI_HOST_AUTOFETCH_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [1:0]       req_op = '0;
  logic [ABITS-1:0] req_addr = '0;
  logic [31:0]      req_data = '0;
  logic             req_ready, rsp_valid, busy, tck, tms, tdi;
  logic [1:0]       rsp_op;
  logic [31:0]      rsp_data;
  logic             tdo = 1'b0;

  jtag_dmi_host #(
    .ABITS(ABITS), .TCK_DIV(TCK_DIV), .IR_LEN(IR_LEN), .IR_DMI(IR_DMI), .RTI_CYCLES(RTI_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural TAP + DMI target ----------------
  typedef enum int {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPsDr, TapEx2Dr, TapUpdDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPsIr, TapEx2Ir, TapUpdIr
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TapTlr:   return m ? TapTlr   : TapRti;
      TapRti:   return m ? TapSelDr : TapRti;
      TapSelDr: return m ? TapSelIr : TapCapDr;
      TapCapDr: return m ? TapEx1Dr : TapShDr;
      TapShDr:  return m ? TapEx1Dr : TapShDr;
      TapEx1Dr: return m ? TapUpdDr : TapPsDr;
      TapPsDr:  return m ? TapEx2Dr : TapPsDr;
      TapEx2Dr: return m ? TapUpdDr : TapShDr;
      TapUpdDr: return m ? TapSelDr : TapRti;
      TapSelIr: return m ? TapTlr   : TapCapIr;
      TapCapIr: return m ? TapEx1Ir : TapShIr;
      TapShIr:  return m ? TapEx1Ir : TapShIr;
      TapEx1Ir: return m ? TapUpdIr : TapPsIr;
      TapPsIr:  return m ? TapEx2Ir : TapPsIr;
      TapEx2Ir: return m ? TapUpdIr : TapShIr;
      TapUpdIr: return m ? TapSelDr : TapRti;
      default:  return TapTlr;
    endcase
  endfunction

  tap_e              tap = TapRti;
  logic [DRW-1:0]    tap_dr = '0;
  logic [IR_LEN-1:0] tap_ir = '0;
  int                sh_bits = 0;
  int                rises = 0;
  int                rsp_pulses = 0;
  logic [33:0]       cap_fifo[$];   // {data, status} the target presents at each Capture-DR
  logic [DRW-1:0]    dr_log[$];     // value seen at each Update-DR
  logic [IR_LEN-1:0] ir_log[$];     // value seen at each Update-IR
  logic              tms_log[$];

  always @(posedge tck) begin
    rises++;
    tms_log.push_back(tms);
    case (tap)
      TapCapDr: begin
        if (cap_fifo.size() > 0) tap_dr = {{ABITS{1'b0}}, cap_fifo.pop_front()};
        else tap_dr = '0;
        sh_bits = 0;
      end
      TapShDr: begin
        tap_dr = {tdi, tap_dr[DRW-1:1]};
        sh_bits++;
      end
      TapUpdDr: dr_log.push_back(tap_dr);
      TapCapIr: tap_ir = IR_LEN'(1);
      TapShIr:  tap_ir = {tdi, tap_ir[IR_LEN-1:1]};
      TapUpdIr: ir_log.push_back(tap_ir);
      default: ;
    endcase
    tap = tap_next(tap, tms);
  end

  always @(negedge tck) begin
    if (tap == TapShDr) tdo = tap_dr[0];
    else if (tap == TapShIr) tdo = tap_ir[0];
    else tdo = 1'b0;
  end

  always @(negedge clk) if (rsp_valid) rsp_pulses++;

  // ---------------- checking ----------------
  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [33:0] cap_at(input int i);
    return (i < cap_fifo.size()) ? cap_fifo[i] : 34'd0;
  endfunction

  // Release reset and check the TAP reset walk up to the first req_ready.
  task automatic release_and_check_tlr();
    int n, r0, t0;
    logic [5:0] pat;
    r0 = rises;
    t0 = tms_log.size();
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tlr_clks", 64'(n), 64'(12 * TCK_DIV));
    chk("tlr_rises", 64'(rises - r0), 64'd6);
    pat = '0;
    for (int i = 0; i < 6; i++) if (t0 + i < tms_log.size()) pat[i] = tms_log[t0 + i];
    chk("tlr_tms", 64'(pat), 64'(6'b011111));
    chk("tlr_tap_rti", 64'(tap == TapRti), 64'd1);
    chk("tlr_park_tck", 64'(tck), 64'd0);
    chk("tlr_park_tms", 64'(tms), 64'd0);
    chk("tlr_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [ABITS-1:0] addr,
                        input logic [31:0] data, input bit exp_ir);
    int n, nscans, exp_rises, r0, d0, i0, p0, lat;
    logic [33:0] c1, exp_rsp;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_req", 64'(req_ready), 64'd1);
    // Request-level prediction: the response is whatever the last scan captured.
    nscans = 1;
    c1 = cap_at(1);
    if (AF) nscans = (c1[1:0] == 2'b11) ? 3 : 2;
    exp_rsp   = cap_at(nscans - 1);
    exp_rises = (exp_ir ? int'(IR_LEN) + 6 : 0) + nscans * (int'(DRW) + 5 + int'(RTI_CYCLES));
    r0 = rises;
    d0 = dr_log.size();
    i0 = ir_log.size();
    p0 = rsp_pulses;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = ABITS'($urandom);
    req_data  = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 64'(lat), 64'(exp_rises * 2 * int'(TCK_DIV) + 1));
    chk("rsp_op", 64'(rsp_op), 64'(exp_rsp[1:0]));
    chk("rsp_data", 64'(rsp_data), 64'(exp_rsp[33:2]));
    chk("tck_rises", 64'(rises - r0), 64'(exp_rises));
    chk("ir_scans", 64'(ir_log.size() - i0), exp_ir ? 64'd1 : 64'd0);
    if (exp_ir && ir_log.size() > i0) chk("ir_value", 64'(ir_log[i0]), 64'(IR_DMI));
    chk("dr_scans", 64'(dr_log.size() - d0), 64'(nscans));
    for (int k = 0; k < nscans && d0 + k < dr_log.size(); k++) begin
      if (k == 0) chk("dr_value", 64'(dr_log[d0]), 64'({addr, data, op}));
      else chk("dr_fetch_value", 64'(dr_log[d0 + k]), 64'({addr, 34'd0}));
    end
    @(posedge clk); #1;
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("rsp_pulses", 64'(rsp_pulses - p0), 64'd1);
    chk("rsp_data_hold", 64'(rsp_data), 64'(exp_rsp[33:2]));
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_park", 64'({busy, tck, tms}), 64'd0);
    chk("idle_tap_rti", 64'(tap == TapRti), 64'd1);
    cap_fifo.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, p0;
    logic [1:0] s;
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_rsp", 64'({rsp_valid, rsp_op, rsp_data}), 64'd0);
    release_and_check_tlr();

    // First write pays for the IR scan; then a read with the target presenting DEADBEEF.
    do_req(2'd2, 7'h10, 32'h0000_0001, 1'b1);
    cap_fifo.push_back({32'hDEAD_BEEF, 2'b00});
    do_req(2'd1, 7'h11, 32'h0, 1'b0);
    // Busy status reported verbatim.
    cap_fifo.push_back({32'h1234_5678, 2'b11});
    do_req(2'd1, 7'h22, 32'h0, 1'b0);
    // Previous ok, fetch busy, second fetch ok.
    cap_fifo.push_back({32'hAAAA_0001, 2'b00});
    cap_fifo.push_back({32'hBBBB_0002, 2'b11});
    cap_fifo.push_back({32'hCCCC_0003, 2'b00});
    do_req(2'd1, 7'h05, 32'h0, 1'b0);
    // op=3 is sent as-is.
    do_req(2'd3, 7'h7F, 32'hFFFF_FFFF, 1'b0);

    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 2))
          0: s = 2'b00;
          1: s = 2'b10;
          default: s = 2'b11;
        endcase
        cap_fifo.push_back({$urandom, s});
      end
      do_req(2'($urandom_range(0, 3)), ABITS'($urandom), $urandom, 1'b0);
    end

    // Reset in the middle of a DR scan.
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    p0 = rsp_pulses;
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_addr  = 7'h33;
    req_data  = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!(tap == TapShDr && sh_bits == 20) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_bit20", 64'(sh_bits), 64'd20);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tms", 64'(tms), 64'd1);
    chk("abort_busy_ready", 64'({busy, req_ready}), 64'(2'b10));
    repeat (2) @(posedge clk);
    #1;
    release_and_check_tlr();
    chk("abort_no_rsp", 64'(rsp_pulses - p0), 64'd0);
    cap_fifo.push_back({32'h0BAD_F00D, 2'b10});
    do_req(2'd1, 7'h44, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
